seg_display_driver: RTL

SEG_DISPLAY_DRIVER -- requirements
Module: seg_display_driver

---
 rtl/seg_display_driver.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/seg_display_driver.sv
// Latches a signed result, converts its magnitude to BCD by double-dabble, and
// multiplexes sign/hundreds/tens/units onto a 4-digit 7-segment display.
module seg_display_driver #(
    parameter int DATA_WIDTH  = 10,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] result,
    input  logic                  error,
    input  logic                  load,
    output logic                  busy,
    output logic [3:0]            anode,
    output logic [6:0]            seg
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] bin_sr;
    logic [11:0]           bcd_sr;
    logic [11:0]           bcd_adj;
    logic [IW-1:0]         iter;
    logic                  lat_neg;
    logic                  lat_err;
    logic [3:0]            disp_units;
    logic [3:0]            disp_tens;
    logic [3:0]            disp_hundreds;
    logic                  disp_neg;
    logic                  disp_err;
    logic [CW-1:0]         refresh_cnt;
    logic [3:0]            digit;

    // One extra bit keeps the most negative input's magnitude representable.
    logic [DATA_WIDTH:0]   res_ext;
    logic [DATA_WIDTH:0]   mag;
    logic                  over;

    assign res_ext = {result[DATA_WIDTH-1], result};
    assign mag     = result[DATA_WIDTH-1] ? (~res_ext + (DATA_WIDTH+1)'(1)) : res_ext;
    assign over    = 32'(mag) > 32'd999;

    always_comb begin
        bcd_adj = bcd_sr;
        for (int i = 0; i < 3; i++) begin
            if (bcd_sr[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
        end
    end

    // Only three BCD digits are kept; anything that would overflow them is
    // already flagged as an error at load time.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            busy          <= 1'b0;
            iter          <= '0;
            bin_sr        <= '0;
            bcd_sr        <= '0;
            lat_neg       <= 1'b0;
            lat_err       <= 1'b0;
            disp_units    <= 4'd0;
            disp_tens     <= 4'd0;
            disp_hundreds <= 4'd0;
            disp_neg      <= 1'b0;
            disp_err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        lat_neg <= result[DATA_WIDTH-1];
                        lat_err <= error | over;
                        bin_sr  <= mag[DATA_WIDTH-1:0];
                        bcd_sr  <= '0;
                        iter    <= '0;
                        busy    <= 1'b1;
                        state   <= CONVERT;
                    end
                end
                CONVERT: begin
                    bcd_sr <= {bcd_adj[10:0], bin_sr[DATA_WIDTH-1]};
                    bin_sr <= bin_sr << 1;
                    iter   <= iter + IW'(1);
                    if (iter == IW'(DATA_WIDTH - 1))
                        state <= COMMIT;
                end
                COMMIT: begin
                    disp_units    <= bcd_sr[3:0];
                    disp_tens     <= bcd_sr[7:4];
                    disp_hundreds <= bcd_sr[11:8];
                    disp_neg      <= lat_neg;
                    disp_err      <= lat_err;
                    busy          <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_cnt <= '0;
            anode       <= 4'b0001;
        end else if (refresh_cnt == CW'(REFRESH_DIV - 1)) begin
            refresh_cnt <= '0;
            anode       <= {anode[2:0], anode[3]};
        end else begin
            refresh_cnt <= refresh_cnt + CW'(1);
        end
    end

    // Digit codes 10 and 11 stand for 'E' and minus.
    always_comb begin
        digit = 4'd0;
        case (anode)
            4'b0001: digit = disp_err ? 4'd10 : disp_units;
            4'b0010: digit = disp_err ? 4'd0 : disp_tens;
            4'b0100: digit = disp_err ? 4'd0 : disp_hundreds;
            4'b1000: digit = (disp_neg && !disp_err) ? 4'd11 : 4'd0;
            default: digit = 4'd0;
        endcase
    end

    always_comb begin
        seg = 7'b1111110;
        case (digit)
            4'd0:    seg = 7'b1111110;
            4'd1:    seg = 7'b0110000;
            4'd2:    seg = 7'b1101101;
            4'd3:    seg = 7'b1111001;
            4'd4:    seg = 7'b0110011;
            4'd5:    seg = 7'b1011011;
            4'd6:    seg = 7'b1011111;
            4'd7:    seg = 7'b1110000;
            4'd8:    seg = 7'b1111111;
            4'd9:    seg = 7'b1111011;
            4'd10:   seg = 7'b1001111;
            4'd11:   seg = 7'b0000001;
            default: seg = 7'b1111110;
        endcase
    end

endmodule
